// File: rtl/mbgd_pkg.sv
// Shared widths, FSM state encoding and default parameters for the
// MBGD dot-product reduction stage.
package mbgd_pkg;

    localparam int DEF_N         = 8;
    localparam int DEF_N_BIT     = 3;
    localparam int DEF_DW1       = 8;
    localparam int DEF_DW2       = 8;
    localparam int DEF_CHUNKS    = 4;
    localparam int DEF_CHUNK_BIT = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_e;

    function automatic int pw_f(input int dw1, input int dw2);
        return dw1 + dw2;
    endfunction

    function automatic int tw_f(input int dw1, input int dw2, input int n_bit);
        return pw_f(dw1, dw2) + n_bit;
    endfunction

    function automatic int aw_f(input int dw1, input int dw2, input int n_bit,
                                input int chunk_bit);
        return tw_f(dw1, dw2, n_bit) + chunk_bit;
    endfunction

endpackage

// File: rtl/mbgd_adder_tree.sv
// Pipelined binary adder tree: one registered level per stage, N_bit stages,
// accepts one chunk of N products every cycle.
module mbgd_adder_tree
    import mbgd_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int N_bit = DEF_N_BIT,
    parameter int PW    = DEF_DW1 + DEF_DW2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  clear,
    input  logic                  in_valid,
    input  logic [PW*N-1:0]       in_data,
    output logic                  out_valid,
    output logic [PW+N_bit-1:0]   out_sum
);

    localparam int TW = PW + N_bit;

    // Heap-indexed tree: node i adds nodes 2i and 2i+1, leaves are N..2N-1.
    // Every node is held at the full tree width; a level-L node never uses
    // more than PW+L bits, so the upper bits of lower levels stay zero.
    logic [TW-1:0]    w_node [2:2*N-1];
    logic [TW-1:0]    r_node [1:N-1];
    logic [N_bit-1:0] r_vld;

    always_comb begin
        w_node = '{default: '0};
        for (int i = 2; i < N; i++) begin
            w_node[i] = r_node[i];
        end
        for (int k = 0; k < N; k++) begin
            w_node[N+k] = TW'(in_data[k*PW +: PW]);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_vld <= '0;
            for (int i = 1; i < N; i++) begin
                r_node[i] <= '0;
            end
        end else begin
            r_vld <= clear ? '0 : N_bit'({r_vld, in_valid});
            for (int i = 1; i < N; i++) begin
                r_node[i] <= w_node[2*i] + w_node[2*i+1];
            end
        end
    end

    assign out_valid = r_vld[N_bit-1];
    assign out_sum   = r_node[1];

endmodule

// File: rtl/mbgd_dot_prod_accum.sv
// Reduces N packed products per chunk through the adder tree and accumulates
// CHUNKS tree sums into one row dot product, flagged by a one-cycle pulse.
module mbgd_dot_prod_accum
    import mbgd_pkg::*;
#(
    parameter int  N         = DEF_N,
    parameter int  N_bit     = DEF_N_BIT,
    parameter int  DW1       = DEF_DW1,
    parameter int  DW2       = DEF_DW2,
    parameter int  CHUNKS    = DEF_CHUNKS,
    parameter int  CHUNK_bit = DEF_CHUNK_BIT,
    localparam int PW        = pw_f(DW1, DW2),
    localparam int TW        = tw_f(DW1, DW2, N_bit),
    localparam int AW        = aw_f(DW1, DW2, N_bit, CHUNK_bit)
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 clear,
    input  logic                 prod_valid,
    input  logic [PW*N-1:0]      prod_in,
    output logic [AW-1:0]        sum_out,
    output logic                 sum_valid,
    output logic [CHUNK_bit-1:0] chunk_cnt,
    output logic                 busy
);

    localparam logic [CHUNK_bit-1:0] LAST_CHUNK = CHUNK_bit'(CHUNKS - 1);

    logic                 w_tree_valid;
    logic [TW-1:0]        w_tree_sum;
    logic [AW-1:0]        w_tree_ext;
    logic [N_bit-1:0]     r_inflight;

    state_e               r_state, w_state_nxt;
    logic [AW-1:0]        r_acc, w_acc_nxt;
    logic [CHUNK_bit-1:0] r_cnt, w_cnt_nxt;
    logic [AW-1:0]        r_sum_out, w_sum_out_nxt;
    logic                 r_sum_valid, w_sum_valid_nxt;

    mbgd_adder_tree #(
        .N     (N),
        .N_bit (N_bit),
        .PW    (PW)
    ) u_tree (
        .clk       (clk),
        .resetn    (resetn),
        .clear     (clear),
        .in_valid  (prod_valid),
        .in_data   (prod_in),
        .out_valid (w_tree_valid),
        .out_sum   (w_tree_sum)
    );

    assign w_tree_ext = AW'(w_tree_sum);

    always_comb begin
        w_state_nxt     = r_state;
        w_acc_nxt       = r_acc;
        w_cnt_nxt       = r_cnt;
        w_sum_out_nxt   = r_sum_out;
        w_sum_valid_nxt = 1'b0;
        if (clear) begin
            w_state_nxt = IDLE;
            w_acc_nxt   = '0;
            w_cnt_nxt   = '0;
        end else if (w_tree_valid) begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = ACCUM;
                    w_acc_nxt   = w_tree_ext;
                    w_cnt_nxt   = CHUNK_bit'(1);
                end
                ACCUM: begin
                    if (r_cnt == LAST_CHUNK) begin
                        w_sum_out_nxt   = r_acc + w_tree_ext;
                        w_sum_valid_nxt = 1'b1;
                        w_acc_nxt       = '0;
                        w_cnt_nxt       = '0;
                        w_state_nxt     = IDLE;
                    end else begin
                        w_acc_nxt = r_acc + w_tree_ext;
                        w_cnt_nxt = r_cnt + CHUNK_bit'(1);
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Occupancy shadow of the tree valid chain, used only for busy.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_sum_out   <= '0;
            r_sum_valid <= 1'b0;
            r_inflight  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_acc       <= w_acc_nxt;
            r_cnt       <= w_cnt_nxt;
            r_sum_out   <= w_sum_out_nxt;
            r_sum_valid <= w_sum_valid_nxt;
            r_inflight  <= clear ? '0 : N_bit'({r_inflight, prod_valid});
        end
    end

    assign sum_out   = r_sum_out;
    assign sum_valid = r_sum_valid;
    assign chunk_cnt = r_cnt;
    assign busy      = (r_state == ACCUM) | (|r_inflight);

endmodule

// File: tb/tb_mbgd_dot_prod_accum.sv
// Directed and random stimulus for mbgd_dot_prod_accum, checked every cycle
// against a delay-queue model of tree latency plus row accumulation.
module tb_mbgd_dot_prod_accum;

    localparam int N         = 8;
    localparam int N_BIT     = 3;
    localparam int DW1       = 8;
    localparam int DW2       = 8;
    localparam int CHUNKS    = 4;
    localparam int CHUNK_BIT = 2;
    localparam int PW        = DW1 + DW2;
    localparam int AW        = PW + N_BIT + CHUNK_BIT;

    logic                 clk = 1'b0;
    logic                 resetn = 1'b0;
    logic                 clear = 1'b0;
    logic                 prod_valid = 1'b0;
    logic [PW*N-1:0]      prod_in = '0;
    logic [AW-1:0]        sum_out;
    logic                 sum_valid;
    logic [CHUNK_BIT-1:0] chunk_cnt;
    logic                 busy;

    always #5 clk = ~clk;

    mbgd_dot_prod_accum #(
        .N(N), .N_bit(N_BIT), .DW1(DW1), .DW2(DW2),
        .CHUNKS(CHUNKS), .CHUNK_bit(CHUNK_BIT)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .clear      (clear),
        .prod_valid (prod_valid),
        .prod_in    (prod_in),
        .sum_out    (sum_out),
        .sum_valid  (sum_valid),
        .chunk_cnt  (chunk_cnt),
        .busy       (busy)
    );

    typedef struct {
        int     c;
        longint s;
    } chunk_t;

    int     errors = 0;
    int     checks = 0;
    int     cyc = 0;
    chunk_t pend[$];
    int     pulse_q[$];
    longint pulse_val[$];
    longint m_acc = 0;
    longint exp_out = 0;
    int     m_cnt = 0;
    bit     exp_sv = 0;
    int     base;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d: got %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [PW*N-1:0] fill(input int v);
        logic [PW*N-1:0] d;
        for (int k = 0; k < N; k++) d[k*PW +: PW] = PW'(v);
        return d;
    endfunction

    function automatic logic [PW*N-1:0] rand_data();
        logic [PW*N-1:0] d;
        for (int k = 0; k < N; k++)
            d[k*PW +: PW] = PW'($urandom_range(0, 255) * $urandom_range(0, 255));
        return d;
    endfunction

    // One clock: drive, advance the model across the edge, then check.
    task automatic step(input logic v, input logic clr, input logic [PW*N-1:0] d);
        longint s = 0;
        prod_valid = v;
        clear      = clr;
        prod_in    = d;
        for (int k = 0; k < N; k++) s += longint'(d[k*PW +: PW]);
        @(posedge clk);
        exp_sv = 0;
        if (clr) begin
            pend.delete();
            m_acc = 0;
            m_cnt = 0;
        end else begin
            if (pend.size() > 0 && pend[0].c == cyc - N_BIT) begin
                chunk_t t = pend.pop_front();
                m_acc += t.s;
                m_cnt++;
                if (m_cnt == CHUNKS) begin
                    exp_sv  = 1;
                    exp_out = m_acc;
                    m_acc   = 0;
                    m_cnt   = 0;
                end
            end
            if (v) pend.push_back(chunk_t'{cyc, s});
        end
        cyc++;
        #1;
        check("sum_valid", {63'd0, sum_valid}, {63'd0, exp_sv});
        check("sum_out", 64'(sum_out), 64'(exp_out));
        check("chunk_cnt", 64'(chunk_cnt), 64'(m_cnt));
        check("busy", {63'd0, busy}, {63'd0, (m_cnt != 0 || pend.size() != 0)});
        if (sum_valid === 1'b1) begin
            pulse_q.push_back(cyc);
            pulse_val.push_back(longint'(sum_out));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
    endtask

    task automatic row(input int v0, input int v1, input int v2, input int v3);
        step(1'b1, 1'b0, fill(v0));
        step(1'b1, 1'b0, fill(v1));
        step(1'b1, 1'b0, fill(v2));
        step(1'b1, 1'b0, fill(v3));
    endtask

    task automatic do_reset();
        prod_valid = 0;
        clear      = 0;
        prod_in    = '0;
        resetn     = 0;
        #2;
        check("rst_sum_out", 64'(sum_out), 64'd0);
        check("rst_sum_valid", {63'd0, sum_valid}, 64'd0);
        check("rst_chunk_cnt", 64'(chunk_cnt), 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        pend.delete();
        m_acc   = 0;
        m_cnt   = 0;
        exp_out = 0;
        exp_sv  = 0;
        @(posedge clk);
        cyc++;
        #1;
        resetn = 1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Row of ones from cycle 0: pulse at cycle 7, value 32.
        cyc = 0;
        pulse_q.delete(); pulse_val.delete();
        row(1, 1, 1, 1);
        idle(6);
        check("t1_pulses", 64'(pulse_q.size()), 64'd1);
        check("t1_cycle", 64'(pulse_q[0]), 64'd7);
        check("t1_sum", 64'(sum_out), 64'd32);
        check("t1_busy", {63'd0, busy}, 64'd0);

        // Maximum products.
        row(65025, 65025, 65025, 65025);
        idle(6);
        check("t2_sum", 64'(sum_out), 64'd2080800);

        // Chunks 1..4 with 2-cycle gaps.
        pulse_q.delete(); pulse_val.delete();
        step(1'b1, 1'b0, fill(1)); idle(2);
        step(1'b1, 1'b0, fill(2)); idle(2);
        step(1'b1, 1'b0, fill(3)); idle(2);
        step(1'b1, 1'b0, fill(4)); idle(6);
        check("t3_pulses", 64'(pulse_q.size()), 64'd1);
        check("t3_sum", 64'(sum_out), 64'd80);

        // Two rows back-to-back.
        pulse_q.delete(); pulse_val.delete();
        base = cyc;
        row(1, 1, 1, 1);
        row(2, 2, 2, 2);
        idle(6);
        check("t4_pulses", 64'(pulse_q.size()), 64'd2);
        check("t4_cycle0", 64'(pulse_q[0] - base), 64'd7);
        check("t4_cycle1", 64'(pulse_q[1] - base), 64'd11);
        check("t4_val0", 64'(pulse_val[0]), 64'd32);
        check("t4_val1", 64'(pulse_val[1]), 64'd64);

        // Clear after two accumulated chunks, with a same-cycle chunk dropped.
        pulse_q.delete(); pulse_val.delete();
        step(1'b1, 1'b0, fill(5));
        step(1'b1, 1'b0, fill(5));
        idle(5);
        step(1'b1, 1'b1, fill(9));
        row(1, 1, 1, 1);
        idle(6);
        check("t5_pulses", 64'(pulse_q.size()), 64'd1);
        check("t5_sum", 64'(sum_out), 64'd32);

        // Clear while chunks are still inside the tree.
        pulse_q.delete(); pulse_val.delete();
        step(1'b1, 1'b0, fill(7));
        step(1'b1, 1'b0, fill(7));
        step(1'b0, 1'b1, '0);
        idle(6);
        check("t5b_pulses", 64'(pulse_q.size()), 64'd0);

        // Reset with two chunks in flight, then a fresh row.
        step(1'b1, 1'b0, fill(3));
        step(1'b1, 1'b0, fill(3));
        do_reset();
        pulse_q.delete(); pulse_val.delete();
        base = cyc;
        row(1, 1, 1, 1);
        idle(6);
        check("t6_pulses", 64'(pulse_q.size()), 64'd1);
        check("t6_cycle", 64'(pulse_q[0] - base), 64'd7);
        check("t6_sum", 64'(sum_out), 64'd32);

        // Random chunks, gaps and occasional clears.
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 31) == 0), rand_data());
        end
        idle(8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mbgd_dot_prod_accum.md
# mbgd_dot_prod_accum

Downstream reduction stage for the MBGD dot-product datapath. It takes the N packed element-wise products from the dot-product multiply stage and reduces them through a pipelined binary adder tree. It then accumulates CHUNKS consecutive tree sums into one full-row dot product and emits that result with a one-cycle valid pulse, which the gradient/update logic consumes.

## Interface
- N, 8, products per input word; must equal 2**N_bit
- N_bit, 3, log2(N); also the number of adder-tree levels
- DW1, 8, width of first multiplicand
- DW2, 8, width of second multiplicand
- CHUNKS, 4, input words per row; must be 2**CHUNK_bit and at least 2
- CHUNK_bit, 2, log2(CHUNKS)
- Derived: PW = DW1+DW2; TW = PW+N_bit; AW = TW+CHUNK_bit
- clk, in, 1, single clock, rising edge
- resetn, in, 1, asynchronous active-low reset
- clear, in, 1, synchronous flush; takes priority over prod_valid
- prod_valid, in, 1, prod_in holds a valid chunk this cycle
- prod_in, in, PW*N, packed unsigned products; product k is at [(k+1)*PW-1 : k*PW]
- sum_out, out, AW, full-row dot product, unsigned
- sum_valid, out, 1, one-cycle pulse; sum_out is valid while it is high
- chunk_cnt, out, CHUNK_bit, index of the next tree sum to be accumulated
- busy, out, 1, high while any chunk is in the tree or partially accumulated

## Operation
- Every input is unsigned and every addition is zero-extended, so no overflow is possible: the AW width bounds N*CHUNKS*(2**DW1-1)*(2**DW2-1).
- Adder tree:
  - Level L (1..N_bit) adds adjacent pairs from level L-1 and registers the result.
  - Each level carries a valid bit registered alongside its data.
  - Level-L sums are PW+L bits wide.
  - The tree is fully pipelined, so it accepts a new chunk every cycle.
- Accumulator and control are a two-state FSM:
  - IDLE: acc = 0 and chunk_cnt = 0.
  - On a tree-output valid in IDLE, go to ACCUM with acc = tree_sum and chunk_cnt = 1.
  - ACCUM: each tree-output valid does acc += tree_sum and chunk_cnt++.
  - On the valid where chunk_cnt == CHUNKS-1: register sum_out = acc + tree_sum, pulse sum_valid, set acc = 0 and chunk_cnt = 0, and return to IDLE.
- There is no backpressure; the consumer must take sum_out on the sum_valid cycle.
- Gaps between prod_valid pulses are allowed. The accumulator holds its value and chunk_cnt holds its count through any gap.
- Back-to-back rows need no bubble. The final chunk of row R and the first chunk of row R+1 may arrive on consecutive cycles.
- busy = (FSM == ACCUM) OR any tree-level valid bit set.
- clear:
  - Zeroes all tree valid bits, acc, and chunk_cnt.
  - Forces the FSM to IDLE.
  - Drives sum_valid to 0 next cycle.
  - Does not change sum_out.
  - A prod_valid in the same cycle is dropped.

## Timing
- Reset values: sum_out = 0, sum_valid = 0, chunk_cnt = 0, busy = 0. All tree data and valid registers are 0, acc = 0, and the FSM is in IDLE.
- Asserting resetn low mid-row drops all in-flight data immediately. After release the block accepts a fresh row.
- Tree latency: the sum for prod_valid at cycle t is present at the tree output in cycle t+N_bit.
- Result latency: if the final chunk of a row is sampled at cycle t, sum_valid is high for exactly cycle t+N_bit+1.
- Throughput is one chunk per cycle, which gives at most one result per CHUNKS cycles.
- sum_out holds its last value until the next sum_valid.

## Structure
- Package mbgd_pkg holds:
  - The PW/TW/AW width functions.
  - The FSM state enum {IDLE, ACCUM}.
  - Shared defaults for N, DW1, DW2, and CHUNKS.
- Sub-module mbgd_adder_tree (parameters N, N_bit, PW):
  - Ports: clk, resetn, clear, in_valid, in_data, out_valid, out_sum.
  - It is a generate-built, registered-per-level tree.
- The top level holds the accumulator, the FSM, the counter, and the output registers.

## Test plan
- Reset, then one row with every product = 1 on 4 consecutive cycles from cycle 0: sum_valid pulses at cycle 7 with sum_out = 32; busy falls afterwards.
- Every product = 65025, 4 chunks: sum_out = 2080800, which fits in the 21-bit AW.
- Chunks of all 1, 2, 3, 4 with 2-cycle gaps between them: sum_out = 80; chunk_cnt reads 1, 2, 3 between the gaps; exactly one sum_valid pulse.
- Two rows back-to-back for 8 consecutive cycles, all 1 then all 2: sum_valid at cycles 7 and 11 with sum_out 32 then 64.
- clear after 2 chunks, then a new 4-chunk row of all 1: no pulse for the aborted row; the new row yields 32.
- resetn low for one cycle while 2 chunks are in flight: all outputs return to reset values; a subsequent row of all 1 yields 32 at the nominal latency.
